usb_fs_in_arb: RTL
==================

// Module: usb_fs_in_arb
// PURPOSE
//   Round-robin arbiter sharing the single 8-bit IN endpoint write port (data_put/data/data_done) of
//   usb_fs_in_pe between NUM_IN_EPS endpoint clients. One client owns the port at a time;
//   owner's strobes and data pass through, others' are blocked. Sits between endpoint logic and IN PE.
// PARAMETERS
//   NUM_IN_EPS  11  number of clients; client i drives IN endpoint i (1..16)
//   MAX_HOLD    64  max grant duration in cycles before forced release; 0 = unlimited
//   HOLD_W      8   width of hold counter; MAX_HOLD must be < 2**HOLD_W
// PORTS
//   clk                 in   1               system clock
//   reset               in   1               sync active-high reset
//   reset_ep            in   NUM_IN_EPS      per-endpoint reset (same as to IN PE)
//   cl_req              in   NUM_IN_EPS      client i requests port
//   cl_grant            out  NUM_IN_EPS      one-hot grant (registered)
//   cl_data_put         in   NUM_IN_EPS      client write strobes
//   cl_data             in   8*NUM_IN_EPS    client data, client i on [8i+7:8i]
//   cl_data_done        in   NUM_IN_EPS      client end-of-packet strobes
//   in_ep_data_put      out  NUM_IN_EPS      to IN PE: cl_data_put & cl_grant
//   in_ep_data          out  8               to IN PE: granted client's data, 0 when none
//   in_ep_data_done     out  NUM_IN_EPS      to IN PE: cl_data_done & cl_grant
//   arb_err             out  1               1-cycle pulse: put/done from non-granted client
// BEHAVIOUR
//   - Interface: one clock (clk); reset synchronous, active-high (reset).
//   - Reset values: cl_grant=0, arb_err=0, hold_cnt=0, state IDLE, last_grant=NUM_IN_EPS-1
//     (client 0 wins first). Combinational outputs follow: all puts/done 0, in_ep_data=0.
//   - FSM states: IDLE, GRANTED, GAP.
//     IDLE: if |cl_req: pick first requester scanning last_grant+1, +2, ... wrapping mod NUM_IN_EPS;
//       next cycle cl_grant = onehot(winner), last_grant<=winner, hold_cnt<=0, -> GRANTED.
//       Latency req->grant = 1 cycle from IDLE. No req: stay IDLE.
//     GRANTED (owner g): hold_cnt increments each cycle, saturating at 2**HOLD_W-1.
//       Release (-> GAP, cl_grant<=0 next cycle) when any of: cl_data_done[g]; !cl_req[g];
//       reset_ep[g]; MAX_HOLD!=0 && hold_cnt==MAX_HOLD-1 (grant lasts exactly MAX_HOLD cycles).
//       Owner's done strobe in release cycle still forwarded (combinational pass-through).
//     GAP: one dead cycle, no grant; -> IDLE. Guarantees IN PE sees put stream boundary.
//   - Pass-through is combinational on registered grant: zero added latency for put/data/done.
//   - in_ep_data: mux on one-hot grant; grant==0 -> 8'h00.
//   - arb_err: registered, set next cycle when (cl_data_put|cl_data_done) & ~cl_grant != 0; blocked
//     strobes are dropped, never queued.
//   - reset_ep[i] for non-owner: no effect on arbitration (request just re-evaluated normally).
//   - Simultaneous done and MAX_HOLD expiry: single release, one GAP cycle.
//   - Owner dropping req and re-raising it in GAP: eligible again, but round-robin puts it last.
//   - reset mid-grant: grant drops next cycle, all state to reset values; in-flight packet lost.
//   - cl_grant is always one-hot or zero; never changes owner without passing GAP.
// TESTING
//   1 After reset, cl_req=0b101 held -> grant 0b001 cycle+1; client0 done -> GAP -> grant 0b100.
//   2 All 11 req held, each done after 4 puts -> grants rotate 0,1,..,10,0; each in_ep_data_put
//     count = 4 per turn, in_ep_data equals owner's cl_data every put cycle.
//   3 MAX_HOLD=64, client3 holds req, never done -> grant drops after exactly 64 cycles, GAP, then
//     next requester (or client3 again if sole requester).
//   4 Client 2 puts 0x5A while client 1 owns -> in_ep_data_put[2]=0, arb_err pulses once next cycle.
//   5 reset_ep[owner] mid-packet -> release, GAP, next grant; reset asserted mid-grant -> cl_grant=0
//     next cycle, first post-reset grant goes to lowest requester index.

Source files
------------

// File: rtl/usb_fs_in_arb.sv
// Round-robin owner of the shared IN PE write port; grant 1 cycle after request from IDLE, put/data/done pass through with 0 latency.
// No backpressure: strobes from non-owners are dropped and flagged on arb_err; every release is followed by a dead GAP cycle.
module usb_fs_in_arb #(
    parameter int NUM_IN_EPS = 11,
    parameter int MAX_HOLD   = 64,
    parameter int HOLD_W     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN_EPS-1:0]   reset_ep,
    input  logic [NUM_IN_EPS-1:0]   cl_req,
    output logic [NUM_IN_EPS-1:0]   cl_grant,
    input  logic [NUM_IN_EPS-1:0]   cl_data_put,
    input  logic [8*NUM_IN_EPS-1:0] cl_data,
    input  logic [NUM_IN_EPS-1:0]   cl_data_done,
    output logic [NUM_IN_EPS-1:0]   in_ep_data_put,
    output logic [7:0]              in_ep_data,
    output logic [NUM_IN_EPS-1:0]   in_ep_data_done,
    output logic                    arb_err
);
    localparam int IDX_W = (NUM_IN_EPS > 1) ? $clog2(NUM_IN_EPS) : 1;
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANTED = 2'd1;
    localparam logic [1:0] GAP     = 2'd2;
    localparam logic [NUM_IN_EPS-1:0] GRANT_ONE = NUM_IN_EPS'(1);

    logic [1:0]        state;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  winner;
    logic              found;
    logic [31:0]       cand;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_expired;
    logic              release_now;

    // Scan starts just after the previous winner so the last owner is considered last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_IN_EPS; k++) begin
            cand = (32'(last_grant) + 32'(k)) % 32'(NUM_IN_EPS);
            if (!found && cl_req[cand[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDX_W-1:0];
            end
        end
    end

    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign release_now  = (|(cl_data_done & cl_grant)) || (|(~cl_req & cl_grant)) ||
                          (|(reset_ep & cl_grant)) || hold_expired;

    assign in_ep_data_put  = cl_data_put & cl_grant;
    assign in_ep_data_done = cl_data_done & cl_grant;

    always_comb begin
        in_ep_data = 8'h00;
        for (int i = 0; i < NUM_IN_EPS; i++) begin
            if (cl_grant[i]) begin
                in_ep_data = in_ep_data | cl_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cl_grant   <= '0;
            last_grant <= IDX_W'(NUM_IN_EPS - 1);
            hold_cnt   <= '0;
            arb_err    <= 1'b0;
        end else begin
            arb_err <= |((cl_data_put | cl_data_done) & ~cl_grant);
            case (state)
                IDLE: begin
                    if (found) begin
                        cl_grant   <= GRANT_ONE << winner;
                        last_grant <= winner;
                        hold_cnt   <= '0;
                        state      <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (hold_cnt != {HOLD_W{1'b1}}) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    if (release_now) begin
                        cl_grant <= '0;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    cl_grant <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
